hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Parametrised hazard unit for the 5-stage core. Supersedes the per-operand forwarding logic.
- Forwarding: generates a forward select for up to NUM_RS source operands in EX.
- Load-use: detects load-use hazards in D.
- Variable-latency memory: freezes the pipeline while a load in MEM waits for dmem_valid.
- Branches: generates flushes for taken branches.
- Monitoring: keeps saturating stall/flush counters and a memory-wait watchdog.

Parameters:
- NUM_RS, 2, number of source operands per instruction (3 for R4-type FMA).
- TIMEOUT, 255, MEM_WAIT cycles before mem_timeout asserts.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- rs_d  in  NUM_RS x 5  source registers of the instruction in D.
- rs_e  in  NUM_RS x 5  source registers of the instruction in EX.
- rd_e  in  5  destination register of the instruction in EX.
- regwrite_e  in  1  instruction in EX writes rd_e.
- memread_e  in  1  instruction in EX is a load.
- rd_m  in  5  destination register of the instruction in MEM.
- regwrite_m  in  1  instruction in MEM writes rd_m.
- memread_m  in  1  instruction in MEM is a load.
- rd_w  in  5  destination register of the instruction in WB.
- regwrite_w  in  1  instruction in WB writes rd_w.
- dmem_valid  in  1  load data is returned this cycle.
- branch_taken_e  in  1  branch or jump in EX redirects the PC.
- fwd_sel  out  NUM_RS x fwd_t  forward select per operand.
- fwd_any  out  1  OR of (fwd_sel[i] != FWD_EX) over all operands.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the stage register.
- flush_d, flush_e, flush_w  out  1 each  insert a bubble into the stage register.
- mem_wait  out  1  registered; FSM is in MEM_WAIT.
- mem_timeout  out  1  registered, sticky watchdog flag.
- stall_cnt  out  CNT_W  cycles with stall_f=1.
- flush_cnt  out  CNT_W  cycles with flush_e=1 caused by a branch.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values:
  - state=RUN, mem_wait=0, mem_timeout=0.
  - wait counter=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs follow from state=RUN.
- Forwarding (combinational, independent per operand i):
  - wm = regwrite_m && rd_m!=0 && !memread_m. A load in MEM is never forwarded.
  - ww = regwrite_w && rd_w!=0.
  - If wm and rd_m==rs_e[i]: FWD_MEM. Else if ww and rd_w==rs_e[i]: FWD_WB. Else FWD_EX.
  - MEM has priority over WB.
- Load-use detection (combinational):
  - lu = regwrite_e && memread_e && rd_e!=0 && (rd_e==rs_d[i] for any i).
- FSM states: RUN and MEM_WAIT.
- RUN:
  - If memread_m && !dmem_valid: next state MEM_WAIT, and the freeze outputs apply this same cycle.
  - Else if branch_taken_e: flush_d=1, flush_e=1, no stall. The branch overrides lu in the same cycle.
  - Else if lu: stall_f=1, stall_d=1, flush_e=1. This is a 1-cycle bubble; the load then reaches WB, where WB forwarding covers it.
  - Otherwise all control outputs are 0.
- MEM_WAIT (freeze):
  - Outputs: stall_f, stall_d, stall_e, stall_m =1; flush_w=1. All other flushes are 0.
  - branch_taken_e and lu are ignored. EX is frozen, so they re-evaluate on exit.
  - Wait counter increments each cycle, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT, mem_timeout is set. It clears only on reset.
  - If dmem_valid=1: next state RUN, counter cleared.
  - The cycle with dmem_valid=1 is still a freeze cycle: stalls held, flush_w=1. The load is captured into WB on the following edge.
- Same-cycle entry: the freeze outputs of a RUN cycle that enters MEM_WAIT are identical to the MEM_WAIT outputs.
- dmem_valid=1 while memread_m=1 in RUN means zero-latency: no wait is entered.
- Counters:
  - stall_cnt increments on each cycle with stall_f=1.
  - flush_cnt increments on each RUN cycle with branch_taken_e=1 that takes effect.
  - Both saturate at all-ones and never wrap.
- Reset mid-MEM_WAIT: immediate return to RUN. All flags and counters clear asynchronously.

Decomposition:
- riscv_defines gains:
  - typedef enum logic [1:0] fwd_t {FWD_EX=0, FWD_MEM=1, FWD_WB=2}, shared by all operand muxes.
  - typedef enum logic hz_state_t {HZ_RUN, HZ_MEM_WAIT}.
- One sub-module, fwd_select: a single-operand priority selector.
  - Inputs: rs, rd_m, wm, rd_w, ww. Output: fwd_t.
  - Instantiated NUM_RS times in a generate loop.
- FSM, watchdog and counters stay in hazard_controller.

Test Plan:
- Forward priority: regwrite_m=1, rd_m=5; regwrite_w=1, rd_w=5; rs_e[0]=5, rs_e[1]=5 -> fwd_sel={FWD_MEM,FWD_MEM}, fwd_any=1. Then rd_m=0 -> {FWD_WB,FWD_WB}.
- x0 and load exclusion: rd_m=0 matching rs_e -> FWD_EX. Then rd_m=7 with memread_m=1 and rs_e[0]=7 -> FWD_EX for that operand.
- Load-use: memread_e=1, regwrite_e=1, rd_e=3, rs_d[1]=3 -> one cycle of stall_f=stall_d=flush_e=1, stall_cnt=1. Same setup plus branch_taken_e=1 -> flush_d=flush_e=1, stall_f=0, flush_cnt=1.
- Memory wait: memread_m=1, dmem_valid low for 4 cycles then high -> freeze outputs for 5 cycles. mem_wait high from the cycle after entry until the cycle after dmem_valid. Counter clears; state returns to RUN.
- Watchdog: TIMEOUT=8, dmem_valid held low 20 cycles -> mem_timeout rises after 8 wait cycles and stays 1 after dmem_valid arrives.
- Async reset: assert rst_n=0 mid-MEM_WAIT, between clock edges -> mem_wait, counters and mem_timeout read 0 immediately, outputs show the RUN state.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types for the hazard unit: forward-select encoding and FSM states.
package hazard_controller_pkg;

    localparam int unsigned REG_W = 5;

    // Operand source chosen by the EX-stage forwarding muxes.
    typedef enum logic [1:0] {
        FWD_EX  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_t;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_controller_fwd_select.sv
// Single-operand forward selector: MEM result wins over WB result.
// Ports:
//   rs   - source register of the EX operand
//   rd_m - MEM destination, wm - MEM result is forwardable
//   rd_w - WB destination,  ww - WB result is forwardable
//   sel  - chosen operand source
module fwd_select
    import hazard_controller_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_m,
    input  logic             wm,
    input  logic [REG_W-1:0] rd_w,
    input  logic             ww,
    output fwd_t             sel
);

    always_comb begin
        sel = FWD_EX;
        if (wm && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (ww && (rd_w == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit for the 5-stage core: operand forwarding, load-use
// bubble, freeze on variable-latency loads, branch flush, saturating
// stall/flush counters and a sticky memory-wait watchdog.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   rs_d / rs_e                - source registers in D / EX
//   rd_e, regwrite_e, memread_e, rd_m, regwrite_m, memread_m,
//   rd_w, regwrite_w           - destination info per stage
//   dmem_valid                 - load data returned this cycle
//   branch_taken_e             - EX redirects the PC
//   fwd_sel, fwd_any           - forward selects (combinational)
//   stall_*, flush_*           - stage register controls (combinational)
//   mem_wait, mem_timeout      - registered status
//   stall_cnt, flush_cnt       - saturating performance counters
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned NUM_RS  = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RS-1:0][REG_W-1:0] rs_d,
    input  logic [NUM_RS-1:0][REG_W-1:0] rs_e,
    input  logic [REG_W-1:0]             rd_e,
    input  logic                         regwrite_e,
    input  logic                         memread_e,
    input  logic [REG_W-1:0]             rd_m,
    input  logic                         regwrite_m,
    input  logic                         memread_m,
    input  logic [REG_W-1:0]             rd_w,
    input  logic                         regwrite_w,
    input  logic                         dmem_valid,
    input  logic                         branch_taken_e,
    output fwd_t [NUM_RS-1:0]            fwd_sel,
    output logic                         fwd_any,
    output logic                         stall_f,
    output logic                         stall_d,
    output logic                         stall_e,
    output logic                         stall_m,
    output logic                         flush_d,
    output logic                         flush_e,
    output logic                         flush_w,
    output logic                         mem_wait,
    output logic                         mem_timeout,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    hz_state_t         state, state_next;
    logic [WCNT_W-1:0] wait_cnt, wait_inc;
    logic              wm, ww, lu;
    logic              branch_fire;

    // A load in MEM has no data yet, so it is never a forwarding source.
    assign wm = regwrite_m && (rd_m != '0) && !memread_m;
    assign ww = regwrite_w && (rd_w != '0);

    for (genvar i = 0; i < NUM_RS; i++) begin : g_fwd
        fwd_select u_fwd_select (
            .rs   (rs_e[i]),
            .rd_m (rd_m),
            .wm   (wm),
            .rd_w (rd_w),
            .ww   (ww),
            .sel  (fwd_sel[i])
        );
    end

    // Any operand taking a bypassed value.
    always_comb begin
        fwd_any = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (fwd_sel[i] != FWD_EX) fwd_any = 1'b1;
        end
    end

    // Load in EX feeding an operand of the instruction in D.
    always_comb begin
        lu = 1'b0;
        if (regwrite_e && memread_e && (rd_e != '0)) begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (rd_e == rs_d[i]) lu = 1'b1;
            end
        end
    end

    // Watchdog count for the current MEM_WAIT cycle, holding at TIMEOUT.
    assign wait_inc = (wait_cnt == WCNT_W'(TIMEOUT)) ? wait_cnt
                                                      : wait_cnt + WCNT_W'(1);

    // Next state and stage controls. Freeze wins over branch, branch over load-use.
    always_comb begin
        state_next  = state;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        branch_fire = 1'b0;
        unique case (state)
            HZ_RUN: begin
                if (memread_m && !dmem_valid) begin
                    state_next = HZ_MEM_WAIT;
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    stall_e    = 1'b1;
                    stall_m    = 1'b1;
                    flush_w    = 1'b1;
                end else if (branch_taken_e) begin
                    flush_d     = 1'b1;
                    flush_e     = 1'b1;
                    branch_fire = 1'b1;
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                // Data-return cycle is still frozen; the load lands in WB next edge.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
                if (dmem_valid) state_next = HZ_RUN;
            end
            default: state_next = HZ_RUN;
        endcase
    end

    // State, status flags, watchdog and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HZ_RUN;
            mem_wait    <= 1'b0;
            mem_timeout <= 1'b0;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state    <= state_next;
            mem_wait <= (state_next == HZ_MEM_WAIT);
            if (state == HZ_MEM_WAIT) begin
                if (wait_inc == WCNT_W'(TIMEOUT)) mem_timeout <= 1'b1;
                wait_cnt <= dmem_valid ? '0 : wait_inc;
            end else begin
                wait_cnt <= '0;
            end
            if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch_fire && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (NUM_RS=2, TIMEOUT=8, CNT_W=6).
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    localparam int TO      = 8;
    localparam int CW      = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_FRZ  = 7'b1111001;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_LU   = 7'b1100010;

    typedef struct {
        logic [4:0] rs_d0, rs_d1, rs_e0, rs_e1, rd_e;
        logic       rw_e, mr_e;
        logic [4:0] rd_m;
        logic       rw_m, mr_m;
        logic [4:0] rd_w;
        logic       rw_w, dv, br;
    } in_t;

    typedef struct {
        in_t        in;
        fwd_t       f0, f1;
        logic       any;
        logic [6:0] ctrl;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0][4:0] rs_d, rs_e;
    logic [4:0] rd_e, rd_m, rd_w;
    logic regwrite_e, memread_e, regwrite_m, memread_m, regwrite_w;
    logic dmem_valid, branch_taken_e;
    fwd_t [1:0] fwd_sel;
    logic fwd_any, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic mem_wait, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit m_wait;
    int m_wcnt;
    bit m_to;
    int m_stall, m_flush;

    hazard_controller #(.NUM_RS(2), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rs_e(rs_e),
        .rd_e(rd_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .memread_m(memread_m),
        .rd_w(rd_w), .regwrite_w(regwrite_w), .dmem_valid(dmem_valid),
        .branch_taken_e(branch_taken_e), .fwd_sel(fwd_sel), .fwd_any(fwd_any),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .mem_wait(mem_wait), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input int rsd0, rsd1, rse0, rse1, rde, rwe, mre,
                               rdm, rwm, mrm, rdw, rww, dv, br);
        in_t v;
        v.rs_d0 = 5'(rsd0); v.rs_d1 = 5'(rsd1);
        v.rs_e0 = 5'(rse0); v.rs_e1 = 5'(rse1);
        v.rd_e = 5'(rde); v.rw_e = 1'(rwe); v.mr_e = 1'(mre);
        v.rd_m = 5'(rdm); v.rw_m = 1'(rwm); v.mr_m = 1'(mrm);
        v.rd_w = 5'(rdw); v.rw_w = 1'(rww);
        v.dv = 1'(dv); v.br = 1'(br);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        rs_d[0] = v.rs_d0; rs_d[1] = v.rs_d1;
        rs_e[0] = v.rs_e0; rs_e[1] = v.rs_e1;
        rd_e = v.rd_e; regwrite_e = v.rw_e; memread_e = v.mr_e;
        rd_m = v.rd_m; regwrite_m = v.rw_m; memread_m = v.mr_m;
        rd_w = v.rd_w; regwrite_w = v.rw_w;
        dmem_valid = v.dv; branch_taken_e = v.br;
    endtask

    // Forwarding rule: newest non-load producer, never x0.
    function automatic fwd_t m_fwd(input logic [4:0] rs, input in_t v);
        if (v.rw_m && !v.mr_m && v.rd_m != 0 && v.rd_m == rs) return FWD_MEM;
        if (v.rw_w && v.rd_w != 0 && v.rd_w == rs) return FWD_WB;
        return FWD_EX;
    endfunction

    function automatic logic [6:0] m_ctrl(input in_t v);
        bit lu;
        lu = v.rw_e && v.mr_e && v.rd_e != 0 && (v.rd_e == v.rs_d0 || v.rd_e == v.rs_d1);
        if (m_wait || (v.mr_m && !v.dv)) return C_FRZ;
        if (v.br) return C_BR;
        if (lu) return C_LU;
        return C_NONE;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_step(input in_t v);
        logic [6:0] c;
        bit frz;
        c   = m_ctrl(v);
        frz = m_wait || (v.mr_m && !v.dv);
        if (c[6] && m_stall < CNT_MAX) m_stall++;
        if (!frz && v.br && m_flush < CNT_MAX) m_flush++;
        if (m_wait) begin
            if (m_wcnt < TO) m_wcnt++;
            if (m_wcnt >= TO) m_to = 1;
            if (v.dv) begin
                m_wait = 0;
                m_wcnt = 0;
            end
        end else if (v.mr_m && !v.dv) begin
            m_wait = 1;
        end
    endtask

    task automatic check_model(input in_t v);
        fwd_t e0, e1;
        e0 = m_fwd(v.rs_e0, v);
        e1 = m_fwd(v.rs_e1, v);
        chk("fwd0", 32'(fwd_sel[0]), 32'(e0));
        chk("fwd1", 32'(fwd_sel[1]), 32'(e1));
        chk("fwd_any", 32'(fwd_any), 32'((e0 != FWD_EX) || (e1 != FWD_EX)));
        chk("ctrl", 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}),
            32'(m_ctrl(v)));
        chk("mem_wait", 32'(mem_wait), 32'(m_wait));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    task automatic apply(input in_t v);
        @(negedge clk);
        drive(v);
        #1;
        check_model(v);
    endtask

    task automatic finish_cycle(input in_t v);
        @(posedge clk);
        if (rst_n) model_step(v);
        else model_reset();
    endtask

    task automatic cycle(input in_t v);
        apply(v);
        finish_cycle(v);
    endtask

    task automatic do_reset();
        in_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        @(negedge clk);
        drive(idle);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model(idle);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[12];
    in_t  idle, ld_wait, ld_done;

    initial begin
        rst_n = 1'b1;
        idle    = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        ld_wait = mk(0,0,0,0,0,0,0,6,1,1,0,0,0,0);
        ld_done = mk(0,0,0,0,0,0,0,6,1,1,0,0,1,0);
        model_reset();
        drive(idle);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mem_wait", 32'(mem_wait), 0);
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        do_reset();

        // rs_d0 rs_d1 rs_e0 rs_e1 rd_e rw_e mr_e rd_m rw_m mr_m rd_w rw_w dv br
        tbl[0]  = '{mk(0,0,5,5,0,0,0,5,1,0,5,1,0,0), FWD_MEM, FWD_MEM, 1'b1, C_NONE};
        tbl[1]  = '{mk(0,0,5,5,0,0,0,0,1,0,5,1,0,0), FWD_WB,  FWD_WB,  1'b1, C_NONE};
        tbl[2]  = '{mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0), FWD_EX,  FWD_EX,  1'b0, C_NONE};
        tbl[3]  = '{mk(0,0,7,2,0,0,0,7,1,1,2,1,1,0), FWD_EX,  FWD_WB,  1'b1, C_NONE};
        tbl[4]  = '{mk(1,3,0,0,3,1,1,0,0,0,0,0,0,0), FWD_EX,  FWD_EX,  1'b0, C_LU};
        tbl[5]  = '{mk(1,3,0,0,3,1,1,0,0,0,0,0,0,1), FWD_EX,  FWD_EX,  1'b0, C_BR};
        tbl[6]  = '{mk(0,4,0,0,0,1,1,0,0,0,0,0,0,0), FWD_EX,  FWD_EX,  1'b0, C_NONE};
        tbl[7]  = '{mk(0,0,0,0,0,0,0,0,0,0,0,1,0,0), FWD_EX,  FWD_EX,  1'b0, C_NONE};
        tbl[8]  = '{mk(0,0,4,9,0,0,0,9,1,0,4,1,0,0), FWD_WB,  FWD_MEM, 1'b1, C_NONE};
        tbl[9]  = '{mk(3,0,0,0,3,1,1,8,1,1,0,0,0,1), FWD_EX,  FWD_EX,  1'b0, C_FRZ};
        tbl[10] = '{mk(3,0,0,0,3,1,1,8,1,1,0,0,1,1), FWD_EX,  FWD_EX,  1'b0, C_FRZ};
        tbl[11] = '{mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0), FWD_EX,  FWD_EX,  1'b0, C_NONE};

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].in);
            chk($sformatf("tbl%0d_fwd0", i), 32'(fwd_sel[0]), 32'(tbl[i].f0));
            chk($sformatf("tbl%0d_fwd1", i), 32'(fwd_sel[1]), 32'(tbl[i].f1));
            chk($sformatf("tbl%0d_any", i), 32'(fwd_any), 32'(tbl[i].any));
            chk($sformatf("tbl%0d_ctrl", i),
                32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}),
                32'(tbl[i].ctrl));
            if (i == 5) begin
                chk("lu_stall_cnt", 32'(stall_cnt), 1);
                chk("br_flush_cnt_before", 32'(flush_cnt), 0);
            end
            if (i == 6) chk("br_flush_cnt_after", 32'(flush_cnt), 1);
            finish_cycle(tbl[i].in);
        end

        // Memory wait: 4 low cycles then valid -> 5 freeze cycles
        do_reset();
        for (int c = 0; c < 5; c++) begin
            apply(c < 4 ? ld_wait : ld_done);
            chk("mw_stall_f", 32'(stall_f), 1);
            chk("mw_flush_w", 32'(flush_w), 1);
            chk("mw_mem_wait", 32'(mem_wait), 32'(c >= 1));
            finish_cycle(c < 4 ? ld_wait : ld_done);
        end
        apply(idle);
        chk("mw_exit_mem_wait", 32'(mem_wait), 0);
        chk("mw_exit_stall_f", 32'(stall_f), 0);
        finish_cycle(idle);
        cycle(ld_done);
        chk("mw_zero_latency", 32'(mem_wait), 0);

        // Watchdog: 20 wait cycles, timeout after 8, sticky past valid
        do_reset();
        cycle(ld_wait);
        for (int j = 0; j < 20; j++) begin
            apply(ld_wait);
            chk("wd_timeout", 32'(mem_timeout), 32'(j >= TO));
            finish_cycle(ld_wait);
        end
        cycle(ld_done);
        apply(idle);
        chk("wd_sticky", 32'(mem_timeout), 1);
        chk("wd_run", 32'(mem_wait), 0);
        finish_cycle(idle);

        // Async reset between edges while in MEM_WAIT
        do_reset();
        for (int j = 0; j < TO + 3; j++) cycle(ld_wait);
        @(negedge clk);
        drive(idle);
        #1;
        chk("ar_pre_stall_f", 32'(stall_f), 1);
        chk("ar_pre_timeout", 32'(mem_timeout), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_mem_wait", 32'(mem_wait), 0);
        chk("ar_timeout", 32'(mem_timeout), 0);
        chk("ar_stall_cnt", 32'(stall_cnt), 0);
        chk("ar_stall_f", 32'(stall_f), 0);
        chk("ar_flush_w", 32'(flush_w), 0);
        check_model(idle);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the reference model; counters saturate at 63
        for (int n = 0; n < 600; n++) begin
            in_t v;
            v = mk($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
                   $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1),
                   $urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,1),
                   ($urandom_range(0,9) < 3), $urandom_range(0,3), $urandom_range(0,1),
                   m_wait ? ($urandom_range(0,9) < 2) : ($urandom_range(0,9) < 5),
                   ($urandom_range(0,9) < 3));
            cycle(v);
        end
        chk("sat_stall_cnt", 32'(stall_cnt), CNT_MAX);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
